// File: rtl/square_add.sv
// Iterative squarer: computes Q*Q + remainder one multiplier bit per clock
// and flags whether the reconstructed radicand equals the reference D.
module square_add #(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [DW-1:0]   Q,
    input  logic [DW-1:0]   remainder,
    input  logic [DW-1:0]   D,
    output logic [2*DW-1:0] result,
    output logic            match,
    output logic            busy,
    output logic            ready
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state, state_next;
    logic [2*DW-1:0] acc, mcand, acc_sum;
    logic [DW-1:0]   mult, dref;
    logic [CW-1:0]   cnt;
    logic            last_iter;

    assign last_iter = (cnt == CW'(1));
    assign acc_sum   = mult[0] ? (acc + mcand) : acc;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        ready      = 1'b0;
        case (state)
            IDLE: if (start) state_next = CALC;
            CALC: begin
                busy = 1'b1;
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands are frozen at accept; the bus is ignored until the next IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            mcand  <= '0;
            mult   <= '0;
            dref   <= '0;
            cnt    <= '0;
            result <= '0;
            match  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc   <= {{DW{1'b0}}, remainder};
                    mcand <= {{DW{1'b0}}, Q};
                    mult  <= Q;
                    dref  <= D;
                    cnt   <= CW'(DW);
                end
                CALC: begin
                    acc   <= acc_sum;
                    mcand <= mcand << 1;
                    mult  <= mult >> 1;
                    cnt   <= cnt - CW'(1);
                    if (last_iter) begin
                        result <= acc_sum;
                        match  <= (acc_sum == {{DW{1'b0}}, dref});
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_square_add.sv
// Directed self-checking bench for square_add with hand-computed results.
module tb_square_add;

    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [DW-1:0]   q, rem, d;
    logic [2*DW-1:0] result;
    logic            match, busy, ready;

    int              total = 0;
    int              bad   = 0;
    logic [2*DW-1:0] last_result = '0;

    square_add #(.DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .Q         (q),
        .remainder (rem),
        .D         (d),
        .result    (result),
        .match     (match),
        .busy      (busy),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive an operation accepted at the next edge (E0); returns at the negedge after E0.
    task automatic accept(input string tag, input logic [DW-1:0] q_i,
                          input logic [DW-1:0] r_i, input logic [DW-1:0] d_i);
        @(negedge clk);
        q     = q_i;
        rem   = r_i;
        d     = d_i;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy_e0"}, busy, 1'b1);
        check({tag, "_ready_e0"}, ready, 1'b0);
        check({tag, "_hold"}, result, last_result);
    endtask

    // Wait for ready (bounded), check latency/results, then the return to IDLE.
    task automatic finish_op(input string tag, input int cyc0,
                             input logic [2*DW-1:0] exp_res, input logic exp_match);
        int cycles = cyc0;
        bit busy_ok = 1'b1;
        while (!ready && cycles < 60) begin
            step();
            cycles++;
            if (!busy) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, cycles, DW);
        check({tag, "_busy_calc"}, busy_ok, 1'b1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_match"}, match, exp_match);
        last_result = exp_res;
        step();
        check({tag, "_ready_off"}, ready, 1'b0);
        check({tag, "_busy_off"}, busy, 1'b0);
    endtask

    initial begin
        int c;
        bit seen;
        reset = 1'b0;
        start = 1'b0;
        q     = '0;
        rem   = '0;
        d     = '0;
        #12;
        check("rst_result", result, 0);
        check("rst_match", match, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", ready, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // 11*11 + 6 = 127
        accept("t1", 16'd11, 16'd6, 16'd127);
        finish_op("t1", 0, 32'd127, 1'b1);

        // 11*11 + 7 = 128 vs 127
        accept("t2", 16'd11, 16'd7, 16'd127);
        finish_op("t2", 0, 32'd128, 1'b0);

        // Largest value: 0xFFFF^2 + 0xFFFF = 0xFFFF0000
        accept("t3", 16'hFFFF, 16'hFFFF, 16'd0);
        finish_op("t3", 0, 32'hFFFF_0000, 1'b0);

        accept("t4", 16'd0, 16'd0, 16'd0);
        finish_op("t4", 0, 32'd0, 1'b1);

        // Start while busy at E5 with new operands must be ignored: 3*3 = 9
        accept("t5", 16'd3, 16'd0, 16'd9);
        for (int i = 0; i < 4; i++) step();
        q     = 16'd5;
        d     = 16'd25;
        start = 1'b1;
        step();
        start = 1'b0;
        finish_op("t5", 5, 32'd9, 1'b1);

        accept("t6", 16'd5, 16'd0, 16'd25);
        finish_op("t6", 0, 32'd25, 1'b1);

        // Start held high: 4*4 = 16, one operation every DW+2 cycles
        @(negedge clk);
        q     = 16'd4;
        rem   = 16'd0;
        d     = 16'd16;
        start = 1'b1;
        c = 0;
        while (!ready && c < 60) begin step(); c++; end
        check("t7_result", result, 32'd16);
        check("t7_match", match, 1'b1);
        step();
        c = 1;
        while (!ready && c < 60) begin step(); c++; end
        check("t7_period", c, DW + 2);
        start = 1'b0;
        step();
        last_result = 32'd16;

        // Reset mid-CALC: 200*200 + 1 in flight at E8
        accept("t8", 16'd200, 16'd1, 16'd0);
        for (int i = 0; i < 7; i++) step();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("t8_rst_result", result, 0);
        check("t8_rst_busy", busy, 1'b0);
        check("t8_rst_ready", ready, 1'b0);
        check("t8_rst_match", match, 1'b0);
        step();
        step();
        reset = 1'b1;
        last_result = '0;
        seen = 1'b0;
        for (int i = 0; i < DW + 4; i++) begin
            step();
            if (ready || busy) seen = 1'b1;
        end
        check("t8_no_pulse", seen, 1'b0);

        // 2*2 + 1 = 5
        accept("t9", 16'd2, 16'd1, 16'd5);
        finish_op("t9", 0, 32'd5, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
